// File: rtl/up_spi_rx_if.sv
// Processor register bus into up_spi_rx: one-cycle write and read handshakes.
interface up_spi_rx_if #(
  parameter int ADDRESS_WIDTH = 12
);
  logic                     up_wreq;
  logic [ADDRESS_WIDTH-1:0] up_waddr;
  logic [31:0]              up_wdata;
  logic                     up_wack;
  logic                     up_rreq;
  logic [ADDRESS_WIDTH-1:0] up_raddr;
  logic [31:0]              up_rdata;
  logic                     up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/up_spi_rx.sv
// SPI mode-0 receive-only slave sampled entirely in the up_clk domain; received
// frames are queued as {bit count, last 32 bits} in a small FIFO read over the up bus.
module up_spi_rx #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int CS_CNT        = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              up_clk,
  input  logic              up_rst,
  input  logic              spi_clk_i,
  input  logic              spi_dat_i,
  input  logic [CS_CNT-1:0] spi_cs_i,
  up_spi_rx_if.slave        up_bus
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = 38;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STATUS = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_DATA   = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_COUNT  = ADDRESS_WIDTH'(2);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_CTRL   = ADDRESS_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_PUSH
  } state_t;

  state_t              state, state_nxt;
  logic                frame_start;

  logic [2:0]          clk_sync;
  logic [1:0]          dat_sync;
  logic [CS_CNT-1:0]   cs_sync1, cs_sync2, cs_dly;
  logic                clk_rise, cs_now, cs_prev, cs_fall, cs_rise;
  logic [3:0]          cur_sel;

  logic                cfg_en;
  logic [3:0]          cfg_sel;
  logic [3:0]          act_sel;
  logic [31:0]         shreg;
  logic [5:0]          bit_cnt;

  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      level;
  logic                overflow;
  logic                fifo_empty, fifo_full;
  logic                push_req, push_ok, pop, flush, ctrl_wr;
  logic [ENTRY_W-1:0]  head;
  logic [31:0]         status, rd_mux;
  logic                wdata_unused;

  // Selecting an index at or beyond CS_CNT yields a permanently deasserted line.
  function automatic logic cs_pick(input logic [CS_CNT-1:0] cs, input logic [3:0] idx);
    logic v;
    v = 1'b1;
    for (int i = 0; i < CS_CNT; i++) begin
      if (idx == 4'(i)) v = cs[i];
    end
    return v;
  endfunction

  // Synchronizers reset to the idle bus: clock low, chip selects high.
  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      clk_sync <= '0;
      dat_sync <= '0;
      cs_sync1 <= '1;
      cs_sync2 <= '1;
      cs_dly   <= '1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
      clk_sync <= {clk_sync[1:0], spi_clk_i};
      dat_sync <= {dat_sync[0], spi_dat_i};
      cs_sync1 <= spi_cs_i;
      cs_sync2 <= cs_sync1;
      cs_dly   <= cs_sync2;
    end
  end

  assign clk_rise = clk_sync[1] & ~clk_sync[2];
  assign cur_sel  = (state == ST_IDLE) ? cfg_sel : act_sel;
  assign cs_now   = cs_pick(cs_sync2, cur_sel);
  assign cs_prev  = cs_pick(cs_dly, cur_sel);
  assign cs_fall  = cs_prev & ~cs_now;
  assign cs_rise  = ~cs_prev & cs_now;

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    state_nxt   = state;
    frame_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_en && cs_fall) begin
          state_nxt   = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!cfg_en)      state_nxt = ST_IDLE;
        else if (cs_rise) state_nxt = ST_PUSH;
      end
      ST_PUSH: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state   <= ST_IDLE;
      act_sel <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        act_sel <= cfg_sel;
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (state == ST_ACTIVE && clk_rise) begin
        shreg <= {shreg[30:0], dat_sync[1]};
        if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (PTR_W + 1)'(FIFO_DEPTH));
  assign ctrl_wr    = up_bus.up_wreq && (up_bus.up_waddr == ADDR_CTRL);
  assign flush      = ctrl_wr && up_bus.up_wdata[31];
  assign pop        = up_bus.up_rreq && (up_bus.up_raddr == ADDR_DATA) && !fifo_empty;
  assign push_req   = (state == ST_PUSH) && (bit_cnt != 6'd0);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      level <= level + (PTR_W + 1)'(1);
      else if (!push_ok && pop) level <= level - (PTR_W + 1)'(1);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; level and pointers alone say which entries are valid.
  always_ff @(posedge up_clk) begin
    if (push_ok && !flush) fifo_mem[wr_ptr] <= {bit_cnt, shreg};
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      cfg_en  <= 1'b0;
      cfg_sel <= '0;
    end else if (ctrl_wr) begin
      cfg_en  <= up_bus.up_wdata[0];
      cfg_sel <= up_bus.up_wdata[7:4];
    end
  end

  assign status = {20'b0, (state != ST_IDLE), overflow, fifo_full, fifo_empty, 8'(level)};

  always_comb begin
    rd_mux = '0;
    case (up_bus.up_raddr)
      ADDR_STATUS: rd_mux = status;
      ADDR_DATA:   rd_mux = fifo_empty ? 32'd0 : head[31:0];
      ADDR_COUNT:  rd_mux = fifo_empty ? 32'd0 : {26'b0, head[37:32]};
      ADDR_CTRL:   rd_mux = {24'b0, cfg_sel, 3'b0, cfg_en};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      up_bus.up_wack  <= 1'b0;
      up_bus.up_rack  <= 1'b0;
      up_bus.up_rdata <= '0;
    end else begin
      up_bus.up_wack  <= up_bus.up_wreq;
      up_bus.up_rack  <= up_bus.up_rreq;
      up_bus.up_rdata <= up_bus.up_rreq ? rd_mux : 32'd0;
    end
  end

  assign wdata_unused = &{1'b0, up_bus.up_wdata[30:8], up_bus.up_wdata[3:1]};

endmodule

// File: doc/up_spi_rx.md
UP_SPI_RX -- requirements
Module: up_spi_rx

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 12, up bus register address width.
REQ-002 SHALL have parameter CS_CNT, default 2, number of SPI chip-select inputs.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-frame FIFO entries (power of two).
REQ-004 SHALL have port up_clk  input  1  sole clock for all logic.
REQ-005 SHALL have port up_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port spi_clk_i  input  1  SPI serial clock, asynchronous to up_clk.
REQ-007 SHALL have port spi_dat_i  input  1  SPI serial data (MOSI), asynchronous.
REQ-008 SHALL have port spi_cs_i  input  CS_CNT  chip selects, active-low, asynchronous.
REQ-009 SHALL have ports up_wreq/up_waddr/up_wdata  input  1/ADDRESS_WIDTH/32  register write request, address, data.
REQ-010 SHALL have port up_wack  output  1  write acknowledge.
REQ-011 SHALL have ports up_rreq/up_raddr  input  1/ADDRESS_WIDTH  register read request, address.
REQ-012 SHALL have ports up_rdata/up_rack  output  32/1  read data, read acknowledge.

Function
REQ-013 SHALL pass spi_clk_i, spi_dat_i, spi_cs_i through 2-flop synchronizers, plus one extra stage on clk and selected cs for edge detection.
REQ-014 SHALL sample synchronized data on each synchronized spi_clk rising edge (SPI mode 0), shifting MSB-first into a 32-bit register: shreg <= {shreg[30:0], dat}.
REQ-015 SHALL keep a 6-bit bit counter, incremented per sampled bit, saturating at 63; shreg holds last 32 bits received.
REQ-016 SHALL implement FSM IDLE, ACTIVE, PUSH.
REQ-017 IDLE -> ACTIVE on falling edge of spi_cs_i[sel] while enable=1; latch sel, clear shreg and counter.
REQ-018 ACTIVE -> PUSH on rising edge of latched chip select; ACTIVE -> IDLE, frame discarded, if enable cleared.
REQ-019 PUSH SHALL last one cycle: write {count, shreg} to FIFO if count != 0, then -> IDLE; zero-bit frames SHALL be discarded.
REQ-020 Push into full FIFO SHALL drop the frame and set sticky overflow; push and pop in same cycle with FIFO full SHALL accept the push.
REQ-021 Simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-022 Writes to cs select during ACTIVE SHALL take effect at the next frame start only.
REQ-023 up_wack and up_rack SHALL each pulse high exactly one cycle after the respective request; up_rdata SHALL be valid only with up_rack, zero otherwise.
REQ-024 Address 0 (R): status {[7:0] level, [8] empty, [9] full, [10] overflow, [11] busy (state != IDLE)}, other bits 0.
REQ-025 Address 1 (R): head frame data, right-justified; read SHALL pop one entry; read when empty SHALL return 0 without pop.
REQ-026 Address 2 (R): head frame bit count in [5:0], no pop; 0 when empty.
REQ-027 Address 3 (R/W): [0] enable, [7:4] cs select index (values >= CS_CNT SHALL select none); write with bit 31 = 1 SHALL flush FIFO and clear overflow (self-clearing, reads 0).
REQ-028 Unmapped addresses SHALL read 0 and ignore writes, still acknowledged.
REQ-029 Pin cs rising edge to FIFO entry visible in status SHALL take at most 5 up_clk cycles.

Reset
REQ-030 up_rst high SHALL asynchronously force: FSM IDLE, FIFO empty, overflow 0, enable 0, sel 0, shreg/counter 0, up_wack 0, up_rack 0, up_rdata 0, synchronizers to idle (cs high, clk low).
REQ-031 Reset mid-frame SHALL discard the frame; after release, reception SHALL resume only on a new cs falling edge with enable set.

Verification
REQ-032 Reset, read addr 0 -> up_rack one cycle later, up_rdata = 0x100.
REQ-033 Write addr 3 = 0x1, send 8-bit frame 0x34 on cs0 -> status 0x001, addr 2 = 8, addr 1 = 0x34, status returns 0x100.
REQ-034 Send 40-bit frame 0x12_3456_789A -> addr 2 = 40, addr 1 = 0x3456789A.
REQ-035 Send 5 frames 0x01..0x05 with depth 4 -> status 0x604; pops return 0x01..0x04; write addr 3 = 0x80000001 -> status 0x100.
REQ-036 Pulse cs0 low with no clocks -> no entry; clear enable mid-frame -> no entry, busy drops to 0.
REQ-037 Select cs1, traffic on cs0 only -> no entry; frame on cs1 -> one entry with correct data.
